// File: rtl/sprite_mem_arbiter_if.sv
// sprite_mem_arbiter_if
// Bundles the arbiter's request/grant signals and its sprite RAM port.
//   rd_req/rd_addr/rd_gnt/rd_valid/rd_data : NREQ pixel-fetch read requesters
//   wr_req/wr_addr/wr_data/wr_window/wr_gnt : host write port
//   mem_*                                   : single-port sprite RAM
// Modports: slave = arbiter view, master = requester/RAM-side view.
interface sprite_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int NREQ   = 2
);
  logic [NREQ-1:0]        rd_req;
  logic [NREQ*ADDR_W-1:0] rd_addr;
  logic [NREQ-1:0]        rd_gnt;
  logic [NREQ-1:0]        rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic                   wr_req;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_window;
  logic                   wr_gnt;
  logic [ADDR_W-1:0]      mem_address;
  logic                   mem_chipselect;
  logic                   mem_write;
  logic [DATA_W-1:0]      mem_writedata;
  logic                   mem_clken;
  logic [DATA_W-1:0]      mem_readdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_window, mem_readdata,
    output rd_gnt, rd_valid, rd_data, wr_gnt,
           mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_window, mem_readdata,
    input  rd_gnt, rd_valid, rd_data, wr_gnt,
           mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
// Shares one single-port sprite RAM (registered address, unregistered q)
// between NREQ round-robin pixel-fetch readers and one host writer.
// At most one access is granted per cycle. Host writes are only eligible
// during the blanking window and may take at most MAX_WR_BURST consecutive
// grants while any read is waiting.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : sprite_mem_arbiter_if.slave (requests, grants, RAM port)
module sprite_mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int NREQ         = 2,
  parameter int MAX_WR_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_mem_arbiter_if.slave   bus
);

  localparam int PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int STREAK_W = $clog2(MAX_WR_BURST + 1);

  logic [PTR_W-1:0]    rr_ptr_r;
  logic [STREAK_W-1:0] wr_streak_r;
  logic [NREQ-1:0]     rd_valid_r;

  logic                wr_elig_s;
  logic                rd_any_s;
  logic                wr_gnt_s;
  logic [NREQ-1:0]     rd_gnt_s;
  logic                rd_gnt_any_s;
  logic                found_s;
  logic [PTR_W-1:0]    rd_idx_s;
  logic [ADDR_W-1:0]   mem_address_s;
  logic [DATA_W-1:0]   mem_writedata_s;
  logic                mem_write_s;
  logic                mem_chipselect_s;

  // Arbitration: write vs. read decision, then round-robin search from rr_ptr.
  always_comb begin
    int idx_v;
    idx_v        = 0;
    wr_elig_s    = bus.wr_req & bus.wr_window;
    rd_any_s     = |bus.rd_req;
    // Writes yield to pending reads once the streak limit is reached.
    wr_gnt_s     = ~reset & wr_elig_s &
                   (~rd_any_s | (wr_streak_r < STREAK_W'(MAX_WR_BURST)));
    rd_gnt_s     = '0;
    rd_idx_s     = '0;
    found_s      = 1'b0;
    if (~reset & ~wr_gnt_s & rd_any_s) begin
      for (int i = 0; i < NREQ; i++) begin
        idx_v = (int'(rr_ptr_r) + i) % NREQ;
        if (!found_s && bus.rd_req[idx_v]) begin
          found_s         = 1'b1;
          rd_gnt_s[idx_v] = 1'b1;
          rd_idx_s        = PTR_W'(idx_v);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      rd_gnt_s = '0;
    end
    rd_gnt_any_s = |rd_gnt_s;
  end

  // RAM port steering: follows whichever source holds the grant.
  always_comb begin
    mem_address_s    = '0;
    mem_writedata_s  = '0;
    mem_write_s      = 1'b0;
    mem_chipselect_s = 1'b0;
    if (wr_gnt_s) begin
      mem_address_s    = bus.wr_addr;
      mem_writedata_s  = bus.wr_data;
      mem_write_s      = 1'b1;
      mem_chipselect_s = 1'b1;
    end else if (rd_gnt_any_s) begin
      mem_address_s    = bus.rd_addr[int'(rd_idx_s)*ADDR_W +: ADDR_W];
      mem_chipselect_s = 1'b1;
    end else begin
      mem_chipselect_s = 1'b0;
    end
  end

  // Arbiter state: round-robin pointer, write streak and read-valid pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r    <= '0;
      wr_streak_r <= '0;
      rd_valid_r  <= '0;
    end else begin
      rd_valid_r <= rd_gnt_s;
      if (rd_gnt_any_s) begin
        rr_ptr_r <= (int'(rd_idx_s) == NREQ - 1) ? '0 : rd_idx_s + PTR_W'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (rd_gnt_any_s || !rd_any_s) begin
        wr_streak_r <= '0;
      end else if (wr_gnt_s && (wr_streak_r < STREAK_W'(MAX_WR_BURST))) begin
        wr_streak_r <= wr_streak_r + STREAK_W'(1);
      end else begin
        wr_streak_r <= wr_streak_r;
      end
    end
  end

  assign bus.rd_gnt         = rd_gnt_s;
  assign bus.wr_gnt         = wr_gnt_s;
  assign bus.rd_valid       = rd_valid_r;
  // RAM q is unregistered, so it lines up with rd_valid the cycle after grant.
  assign bus.rd_data        = bus.mem_readdata;
  assign bus.mem_address    = mem_address_s;
  assign bus.mem_writedata  = mem_writedata_s;
  assign bus.mem_write      = mem_write_s;
  assign bus.mem_chipselect = mem_chipselect_s;
  assign bus.mem_clken      = ~reset;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed testbench for sprite_mem_arbiter with a behavioural sprite RAM
// (registered address, unregistered q).
module tb_sprite_mem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int NREQ   = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   multi_gnt_cnt;

  sprite_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREQ(NREQ)) bus ();

  sprite_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREQ(NREQ), .MAX_WR_BURST(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] ram [0:4095];
  logic [ADDR_W-1:0] ram_addr_q;

  always #5 clk = ~clk;

  // Sprite RAM model
  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
      ram_addr_q <= bus.mem_address;
    end
  end
  assign bus.mem_readdata = ram[ram_addr_q];

  // Counts any cycle with more than one grant
  always @(negedge clk) begin
    if (!$onehot0({bus.rd_gnt, bus.wr_gnt})) multi_gnt_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req    = '0;
    bus.wr_req    = 1'b0;
    bus.wr_window = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.rd_req = 2'b11;
    step();
    total++;
    if ({bus.rd_gnt, bus.wr_gnt, bus.mem_chipselect, bus.mem_clken, bus.rd_valid} !== 7'b0) begin
      $display("FAIL reset_state: got %b want 0000000",
               {bus.rd_gnt, bus.wr_gnt, bus.mem_chipselect, bus.mem_clken, bus.rd_valid});
      bad++;
    end
    reset = 1'b0;
    bus.rd_req = 2'b01;
    bus.rd_addr[0 +: ADDR_W] = 12'h100;
    #1;
    total++;
    if (bus.rd_gnt !== 2'b01) begin
      $display("FAIL reset_first_gnt: got %b want 01", bus.rd_gnt); bad++;
    end
    step();
    // rd_valid captured; now reset arrives mid-stream
    reset = 1'b1;
    #1;
    total++;
    if ({bus.rd_valid, bus.mem_clken} !== 3'b000) begin
      $display("FAIL reset_drop_valid: got %b want 000", {bus.rd_valid, bus.mem_clken}); bad++;
    end
    step();
    reset = 1'b0;
    bus.rd_req = 2'b11;
    bus.rd_addr[ADDR_W +: ADDR_W] = 12'h200;
    #1;
    total++;
    if (bus.rd_gnt !== 2'b01) begin
      $display("FAIL reset_ptr_zero: got %b want 01", bus.rd_gnt); bad++;
    end
    step();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {2'b01, 8'h11}) begin
      $display("FAIL reset_readback: got %b/%h want 01/11", bus.rd_valid, bus.rd_data); bad++;
    end
    bus.rd_req = '0;
  endtask

  task automatic test_single_requester();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 2'b10;
      bus.rd_addr[ADDR_W +: ADDR_W] = 12'h010 + 12'(i);
      #1;
      total++;
      if ({bus.rd_gnt, bus.mem_address} !== {2'b10, 12'h010 + 12'(i)}) begin
        $display("FAIL single_gnt[%0d]: got %b/%h want 10/%h", i, bus.rd_gnt,
                 bus.mem_address, 12'h010 + 12'(i)); bad++;
      end
      step();
      total++;
      if ({bus.rd_valid, bus.rd_data} !== {2'b10, exp_d[i]}) begin
        $display("FAIL single_data[%0d]: got %b/%h want 10/%h", i, bus.rd_valid,
                 bus.rd_data, exp_d[i]); bad++;
      end
    end
    bus.rd_req = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    bus.rd_addr[0 +: ADDR_W]      = 12'h100;
    bus.rd_addr[ADDR_W +: ADDR_W] = 12'h200;
    bus.rd_req    = 2'b11;
    bus.wr_window = 1'b0;
    for (int c = 0; c < 6; c++) begin
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (c % 2 == 0) ? 8'h11 : 8'h22;
      #1;
      total++;
      if ({bus.rd_gnt, bus.wr_gnt} !== {exp_g, 1'b0}) begin
        $display("FAIL rr_gnt[%0d]: got %b want %b", c, {bus.rd_gnt, bus.wr_gnt}, {exp_g, 1'b0}); bad++;
      end
      step();
      total++;
      if ({bus.rd_valid, bus.rd_data} !== {exp_g, exp_d}) begin
        $display("FAIL rr_data[%0d]: got %b/%h want %b/%h", c, bus.rd_valid,
                 bus.rd_data, exp_g, exp_d); bad++;
      end
    end
    bus.rd_req = '0;
  endtask

  task automatic test_write_burst();
    // W W W W R W W : streak saturates at 4, cleared by the read grant
    logic [6:0] exp_w;
    exp_w = 7'b1101111;
    bus.wr_req    = 1'b1;
    bus.wr_window = 1'b1;
    bus.wr_addr   = 12'h300;
    bus.wr_data   = 8'h77;
    bus.rd_req    = 2'b01;
    bus.rd_addr[0 +: ADDR_W] = 12'h100;
    for (int c = 0; c < 7; c++) begin
      #1;
      total++;
      if ({bus.wr_gnt, bus.mem_write, bus.rd_gnt} !==
          {exp_w[c], exp_w[c], 1'b0, ~exp_w[c]}) begin
        $display("FAIL burst_gnt[%0d]: got %b want %b", c,
                 {bus.wr_gnt, bus.mem_write, bus.rd_gnt}, {exp_w[c], exp_w[c], 1'b0, ~exp_w[c]});
        bad++;
      end
      step();
      if (!exp_w[c]) begin
        total++;
        if ({bus.rd_valid, bus.rd_data} !== {2'b01, 8'h11}) begin
          $display("FAIL burst_read: got %b/%h want 01/11", bus.rd_valid, bus.rd_data); bad++;
        end
      end
    end
    total++;
    if (ram[12'h300] !== 8'h77) begin
      $display("FAIL burst_ram: got %h want 77", ram[12'h300]); bad++;
    end
    idle_inputs();
  endtask

  task automatic test_window();
    bus.wr_req    = 1'b1;
    bus.wr_window = 1'b0;
    bus.wr_addr   = 12'h400;
    bus.wr_data   = 8'h9E;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({bus.wr_gnt, bus.mem_chipselect} !== 2'b00) begin
        $display("FAIL window_closed[%0d]: got %b want 00", c, {bus.wr_gnt, bus.mem_chipselect}); bad++;
      end
      step();
    end
    bus.wr_window = 1'b1;
    #1;
    total++;
    if ({bus.wr_gnt, bus.mem_write, bus.mem_address, bus.mem_writedata} !==
        {1'b1, 1'b1, 12'h400, 8'h9E}) begin
      $display("FAIL window_open: got %b%b/%h/%h want 11/400/9e", bus.wr_gnt,
               bus.mem_write, bus.mem_address, bus.mem_writedata); bad++;
    end
    step();
    idle_inputs();
    bus.rd_req = 2'b01;
    bus.rd_addr[0 +: ADDR_W] = 12'h400;
    #1;
    total++;
    if (bus.rd_gnt !== 2'b01) begin
      $display("FAIL window_rd_gnt: got %b want 01", bus.rd_gnt); bad++;
    end
    step();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {2'b01, 8'h9E}) begin
      $display("FAIL window_readback: got %b/%h want 01/9e", bus.rd_valid, bus.rd_data); bad++;
    end
    bus.rd_req = '0;
  endtask

  task automatic test_same_addr();
    bus.wr_req    = 1'b1;
    bus.wr_window = 1'b1;
    bus.wr_addr   = 12'hFFF;
    bus.wr_data   = 8'h5C;
    bus.rd_req    = 2'b10;
    bus.rd_addr[ADDR_W +: ADDR_W] = 12'hFFF;
    #1;
    total++;
    if ({bus.wr_gnt, bus.rd_gnt, bus.mem_address, bus.mem_writedata} !==
        {1'b1, 2'b00, 12'hFFF, 8'h5C}) begin
      $display("FAIL same_wr: got %b%b/%h/%h want 100/fff/5c", bus.wr_gnt,
               bus.rd_gnt, bus.mem_address, bus.mem_writedata); bad++;
    end
    step();
    bus.wr_req = 1'b0;
    #1;
    total++;
    if ({bus.wr_gnt, bus.rd_gnt, bus.mem_address} !== {1'b0, 2'b10, 12'hFFF}) begin
      $display("FAIL same_rd: got %b%b/%h want 010/fff", bus.wr_gnt, bus.rd_gnt, bus.mem_address); bad++;
    end
    step();
    bus.rd_req = '0;
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {2'b10, 8'h5C}) begin
      $display("FAIL same_readback: got %b/%h want 10/5c", bus.rd_valid, bus.rd_data); bad++;
    end
    step();
    total++;
    if (bus.rd_valid !== 2'b00) begin
      $display("FAIL valid_single_pulse: got %b want 00", bus.rd_valid); bad++;
    end
    total++;
    if (multi_gnt_cnt !== 0) begin
      $display("FAIL onehot_grant: got %0d multi-grant cycles want 0", multi_gnt_cnt); bad++;
    end
  endtask

  initial begin
    clk           = 1'b0;
    reset         = 1'b1;
    total         = 0;
    bad           = 0;
    multi_gnt_cnt = 0;
    bus.rd_req    = '0;
    bus.rd_addr   = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_window = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    ram[12'h010] <= 8'hA0;
    ram[12'h011] <= 8'hA1;
    ram[12'h012] <= 8'hA2;
    ram[12'h100] <= 8'h11;
    ram[12'h200] <= 8'h22;
    ram_addr_q   <= '0;
    #2;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_write_burst();
    test_window();
    test_same_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
